// File: rtl/uart_rx_fifo_if.sv
// Bundle of the UART RX FIFO write, read and status signals between receiver/consumer and the FIFO.
// Latency: none; this is wiring only.
// Backpressure: rd_ready from the consumer; the write side has none, and a dropped push is reported via overrun.
// Optional almost_full member present only when UART_RX_FIFO_WMARK_EN is defined.
interface uart_rx_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              overrun;
    logic              ovr_clr;
    logic              flush;
`ifdef UART_RX_FIFO_WMARK_EN
    logic              almost_full;
`endif

    // Receiver plus consumer side: drives strobes, observes FIFO state
    modport master (
        output wr_en, wr_data, rd_ready, ovr_clr, flush,
        input  rd_valid, rd_data, count, full, empty, overrun
`ifdef UART_RX_FIFO_WMARK_EN
        , input almost_full
`endif
    );

    // FIFO side
    modport slave (
        input  wr_en, wr_data, rd_ready, ovr_clr, flush,
        output rd_valid, rd_data, count, full, empty, overrun
`ifdef UART_RX_FIFO_WMARK_EN
        , output almost_full
`endif
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: captures rx_done bytes and serves them first-word fall-through.
// Latency: a byte pushed at edge N is on rd_data with rd_valid=1 in cycle N+1.
// Backpressure: rd_ready stalls reads; a push while full and not popping is dropped and sets sticky overrun.
// Optional feature macro: UART_RX_FIFO_WMARK_EN adds almost_full = (count >= WMARK).
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int WMARK  = 12
) (
    input  logic            clk,
    input  logic            rstn,
    uart_rx_fifo_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Parameter sanity, caught at elaboration
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
    end
    if ((WMARK < 1) || (WMARK > DEPTH)) begin : g_bad_wmark
        $error("uart_rx_fifo: WMARK must be in 1..DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              overrun_q;

    logic full_c;
    logic empty_c;
    logic pop;
    logic push;
    logic drop;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);

    // Flush wins over everything: a coincident byte is discarded, not counted as an overrun
    assign pop  = !empty_c && bus.rd_ready && !bus.flush;
    assign push = bus.wr_en && (!full_c || pop) && !bus.flush;
    assign drop = bus.wr_en && full_c && !pop && !bus.flush;

    // Pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    // Sticky overrun; a new drop beats a coincident clear, flush leaves it alone
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.count    = count_q;
    assign bus.full     = full_c;
    assign bus.empty    = empty_c;
    assign bus.rd_valid = !empty_c;
    assign bus.rd_data  = empty_c ? '0 : mem[rd_ptr];
    assign bus.overrun  = overrun_q;
`ifdef UART_RX_FIFO_WMARK_EN
    assign bus.almost_full = (count_q >= CNT_W'(WMARK));
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue-based reference model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: rd_ready randomized; the model drops pushes when full and not popping.
module tb_uart_rx_fifo;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;
    localparam int WMARK  = 12;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    // Reference model state: stored bytes oldest first, plus sticky overrun flag
    logic [DATA_W-1:0] q[$];
    logic              m_ovr;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .WMARK(WMARK)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the model
    task automatic check_all(input string tag);
        logic [DATA_W-1:0] exp_dat;
        exp_dat = (q.size() > 0) ? q[0] : '0;
        chk({tag, ".count"},    32'(bus.count),    32'(q.size()));
        chk({tag, ".empty"},    32'(bus.empty),    32'(q.size() == 0));
        chk({tag, ".full"},     32'(bus.full),     32'(q.size() == DEPTH));
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(q.size() > 0));
        chk({tag, ".rd_data"},  32'(bus.rd_data),  32'(exp_dat));
        chk({tag, ".overrun"},  32'(bus.overrun),  32'(m_ovr));
`ifdef UART_RX_FIFO_WMARK_EN
        chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(q.size() >= WMARK));
`endif
    endtask

    // One clock: drive inputs, advance the model, take the edge, then compare
    task automatic cycle(input string tag, input logic we, input logic [DATA_W-1:0] wd,
                         input logic rr, input logic oc, input logic fl);
        bit m_pop;
        bit m_drop;
        bus.wr_en    = we;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        bus.ovr_clr  = oc;
        bus.flush    = fl;
        m_pop  = (q.size() > 0) && rr && !fl;
        m_drop = we && !fl && (q.size() == DEPTH) && !m_pop;
        if (m_drop)  m_ovr = 1'b1;
        else if (oc) m_ovr = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (we && !m_drop) q.push_back(wd);
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_ovr  = 1'b0;
        rstn   = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        bus.ovr_clr  = 1'b0;
        bus.flush    = 1'b0;

        // 1: reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset");

        // 2: three bytes in, then drained in order
        cycle("t2_push", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("t2_first_visible", 32'(bus.rd_data), 32'h0000_00A5);
        cycle("t2_push", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        cycle("t2_push", 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
        chk("t2_count3", 32'(bus.count), 32'd3);
        repeat (3) cycle("t2_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t2_drained", 32'(bus.rd_valid), 32'd0);

        // 3: fill, overflow, drain, clear overrun
        for (int i = 0; i < DEPTH; i++) cycle("t3_fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("t3_full", 32'(bus.full), 32'd1);
        cycle("t3_overflow", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("t3_overrun", 32'(bus.overrun), 32'd1);
        for (int i = 0; i < DEPTH; i++) cycle("t3_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle("t3_ovr_clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("t3_ovr_cleared", 32'(bus.overrun), 32'd0);

        // 4: simultaneous push/pop while full, then a long wrap run
        for (int i = 0; i < DEPTH; i++) cycle("t4_fill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        cycle("t4_full_pp", 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        chk("t4_count16", 32'(bus.count), 32'd16);
        chk("t4_no_ovr", 32'(bus.overrun), 32'd0);
        for (int i = 0; i < 40; i++) cycle("t4_wrap", 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle("t4_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // 5: push/pop on empty, then flush with coincident write while overrun set
        cycle("t5_empty_pp", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        chk("t5_count1", 32'(bus.count), 32'd1);
        for (int i = 0; i < DEPTH; i++) cycle("t5_fill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        chk("t5_ovr_set", 32'(bus.overrun), 32'd1);
        cycle("t5_flush", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("t5_flush_empty", 32'(bus.empty), 32'd1);
        chk("t5_flush_ovr_kept", 32'(bus.overrun), 32'd1);
        for (int i = 0; i < 5; i++) cycle("t5_fill5", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        cycle("t5_flush5", 1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
        chk("t5_flush5_count", 32'(bus.count), 32'd0);
        idle();

`ifdef UART_RX_FIFO_WMARK_EN
        // 6: watermark edges
        for (int i = 0; i < WMARK - 1; i++) cycle("t6_fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("t6_below", 32'(bus.almost_full), 32'd0);
        cycle("t6_mark", 1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
        chk("t6_at", 32'(bus.almost_full), 32'd1);
        cycle("t6_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t6_after_pop", 32'(bus.almost_full), 32'd0);
        cycle("t6_flush", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`endif

        // Randomized traffic with occasional clears and flushes
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  $urandom_range(0, 99) < 60,
                  8'($urandom),
                  $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 2);
        end

        // Reset mid-burst discards everything
        for (int i = 0; i < 6; i++) cycle("rst_fill", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        cycle("rst_ovr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h77;
        rstn        = 1'b0;
        #1;
        q.delete();
        m_ovr = 1'b0;
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("held_reset");
        @(negedge clk);
        bus.wr_en = 1'b0;
        rstn      = 1'b1;
        idle();
        cycle("after_reset_push", 1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        cycle("after_reset_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
